// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU definitions for the multiply sequencer: control-bit weights,
// the two control words the sequencer issues, and its state encoding.
package alu_mul_seq_pkg;

  // ALU control word bit weights, packed as {ex,nx,ey,ny,f,no}
  localparam logic [5:0] ALU_EX = 6'd32;
  localparam logic [5:0] ALU_NX = 6'd16;
  localparam logic [5:0] ALU_EY = 6'd8;
  localparam logic [5:0] ALU_NY = 6'd4;
  localparam logic [5:0] ALU_F  = 6'd2;
  localparam logic [5:0] ALU_NO = 6'd1;

  // Builds a control word from individual flags so the named words below
  // read the same way the ALU documentation lists them.
  function automatic logic [5:0] alu_ctrl(input logic ex, input logic nx,
                                          input logic ey, input logic ny,
                                          input logic f,  input logic no);
    logic [5:0] w;
    w = 6'd0;
    if (ex) w = w | ALU_EX;
    if (nx) w = w | ALU_NX;
    if (ey) w = w | ALU_EY;
    if (ny) w = w | ALU_NY;
    if (f)  w = w | ALU_F;
    if (no) w = w | ALU_NO;
    return w;
  endfunction

  // x + y  (6'b101010)
  localparam logic [5:0] ALU_ADD   = alu_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  // x + 0  (6'b100010)
  localparam logic [5:0] ALU_PASSX = alu_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiply sequencer driving an external combinational
// ALU. Returns the low 16 bits of a*b with a start/busy/done handshake.
// Optional feature: define MUL_EARLY_EXIT_EN to stop stepping as soon as the
// remaining multiplier bits are all zero (b=0 goes straight to DONE).
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_c,
  input  logic [15:0] alu_out
);

  localparam int CNT_W = $clog2(ITERS + 1);

  state_t           state_reg,  state_next;
  logic [15:0]      acc_reg,    acc_next;
  logic [15:0]      mcand_reg,  mcand_next;
  logic [15:0]      mplier_reg, mplier_next;
  logic [15:0]      result_reg, result_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic             last_step;

  // Decide whether the current STEP cycle is the final shift-add step
  always_comb begin
    last_step = (count_reg == CNT_W'(ITERS - 1));
`ifdef MUL_EARLY_EXIT_EN
    // Nothing left to add once the shifted multiplier is empty
    if ((mplier_reg >> 1) == 16'd0) last_step = 1'b1;
`endif
  end

  // Next-state and datapath update for IDLE/STEP/DONE
  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    count_next  = count_reg;
    result_next = result_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          acc_next    = 16'd0;
          mcand_next  = a;
          mplier_next = b;
          count_next  = '0;
          state_next  = ST_STEP;
`ifdef MUL_EARLY_EXIT_EN
          if (b == 16'd0) begin
            state_next  = ST_DONE;
            result_next = 16'd0;
          end
`endif
        end
      end
      ST_STEP: begin
        // The ALU either adds the shifted multiplicand or passes acc through
        acc_next    = alu_out;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + CNT_W'(1);
        if (last_step) begin
          state_next = ST_DONE;
          // Load result on the way into DONE so it is valid alongside done
          result_next = alu_out;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      acc_reg    <= 16'd0;
      mcand_reg  <= 16'd0;
      mplier_reg <= 16'd0;
      count_reg  <= '0;
      result_reg <= 16'd0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_next;
      result_reg <= result_next;
    end
  end

  // Handshake and ALU bus outputs decoded from the current state
  always_comb begin
    busy   = (state_reg != ST_IDLE);
    done   = (state_reg == ST_DONE);
    result = result_reg;
    alu_x  = acc_reg;
    alu_y  = 16'd0;
    alu_c  = ALU_PASSX;
    if (state_reg == ST_STEP) begin
      alu_y = mcand_reg;
      if (mplier_reg[0]) alu_c = ALU_ADD;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural ALU on the alu_* bus.
// Expected results come from plain (a*b) mod 65536 arithmetic; expected
// latency comes from the operand bit count. Honours MUL_EARLY_EXIT_EN.
module tb_alu_mul_seq;

  localparam logic [5:0] C_ADD   = 6'b101010;
  localparam logic [5:0] C_PASSX = 6'b100010;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_c;

  int tests = 0;
  int fails = 0;

  alu_mul_seq #(.ITERS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_x(alu_x), .alu_y(alu_y), .alu_c(alu_c), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // The existing ALU: {ex,nx,ey,ny,f,no}, carry dropped
  logic [15:0] xx, yy, oo;
  always_comb begin
    xx = alu_c[5] ? alu_x : 16'd0;
    if (alu_c[4]) xx = ~xx;
    yy = alu_c[3] ? alu_y : 16'd0;
    if (alu_c[2]) yy = ~yy;
    oo = alu_c[1] ? 16'(xx + yy) : (xx & yy);
    if (alu_c[0]) oo = ~oo;
    alu_out = oo;
  end

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = {16'd0, x} * {16'd0, y};
    return p[15:0];
  endfunction

  // Clocks from accept edge to the cycle in which done is high
  function automatic int exp_lat(input logic [15:0] y);
`ifdef MUL_EARLY_EXIT_EN
    for (int i = 15; i >= 0; i--) if (y[i]) return i + 2;
    return 1;
`else
    return 17;
`endif
  endfunction

  // Issue one multiply and observe it; lat stays 0 if done never arrives
  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob,
                        output logic [15:0] res, output int lat,
                        output int busy_cnt, output int done_cnt);
    lat = 0; busy_cnt = 0; done_cnt = 0; res = 16'd0;
    @(negedge clk);
    a = oa; b = ob; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin lat = cyc; res = result; end
      end
      if (lat != 0 && cyc >= lat + 2) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = 16'd0; b = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b expected 0", done); end
    tests++; if (result !== 16'd0) begin fails++; $display("FAIL reset_result: got %0d expected 0", result); end
    tests++; if (alu_x !== 16'd0) begin fails++; $display("FAIL reset_alu_x: got %0d expected 0", alu_x); end
    tests++; if (alu_y !== 16'd0) begin fails++; $display("FAIL reset_alu_y: got %0d expected 0", alu_y); end
    tests++; if (alu_c !== C_PASSX) begin fails++; $display("FAIL reset_alu_c: got %b expected %b", alu_c, C_PASSX); end
    $display("[TB] reset: busy=%0b done=%0b result=%0d", busy, done, result);
  endtask

  task automatic test_basic;
    logic [15:0] r; int lat, bc, dc;
    run_op(16'd3, 16'd5, r, lat, bc, dc);
    tests++; if (r !== 16'd15) begin fails++; $display("FAIL basic_result: got %0d expected 15", r); end
    tests++; if (lat != exp_lat(16'd5)) begin fails++; $display("FAIL basic_latency: got %0d expected %0d", lat, exp_lat(16'd5)); end
    tests++; if (bc != exp_lat(16'd5)) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, exp_lat(16'd5)); end
    tests++; if (dc != 1) begin fails++; $display("FAIL basic_done_pulses: got %0d expected 1", dc); end
    $display("[TB] basic 3*5: result=%0d latency=%0d busy=%0d", r, lat, bc);
  endtask

  task automatic test_corners;
    logic [15:0] ta [5] = '{16'd300, 16'hFFFF, 16'd11, 16'd1234, 16'd1};
    logic [15:0] tb [5] = '{16'd300, 16'hFFFF, 16'd5, 16'd0, 16'h8000};
    logic [15:0] te [5] = '{16'd24464, 16'd1, 16'd55, 16'd0, 16'h8000};
    logic [15:0] r; int lat, bc, dc;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], r, lat, bc, dc);
      tests++; if (r !== te[i]) begin fails++; $display("FAIL corner_result %0d*%0d: got %0d expected %0d", ta[i], tb[i], r, te[i]); end
      tests++; if (lat != exp_lat(tb[i])) begin fails++; $display("FAIL corner_latency %0d*%0d: got %0d expected %0d", ta[i], tb[i], lat, exp_lat(tb[i])); end
      tests++; if (dc != 1) begin fails++; $display("FAIL corner_done_pulses %0d*%0d: got %0d expected 1", ta[i], tb[i], dc); end
      $display("[TB] corner %0d*%0d: result=%0d latency=%0d", ta[i], tb[i], r, lat);
    end
  endtask

  task automatic test_ignored_start;
    int lat = 0, dc = 0;
    logic [15:0] r = 16'd0;
    @(negedge clk);
    a = 16'd3; b = 16'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin dc++; if (lat == 0) begin lat = cyc; r = result; end end
      if (cyc == 4) begin a = 16'd7; b = 16'd9; start = 1'b1; end
      if (cyc == 5) start = 1'b0;
    end
    tests++; if (r !== 16'd15) begin fails++; $display("FAIL ignored_start_result: got %0d expected 15", r); end
    tests++; if (dc != 1) begin fails++; $display("FAIL ignored_start_done_pulses: got %0d expected 1", dc); end
    tests++; if (lat != exp_lat(16'd5)) begin fails++; $display("FAIL ignored_start_latency: got %0d expected %0d", lat, exp_lat(16'd5)); end
    $display("[TB] ignored start: result=%0d done_pulses=%0d", r, dc);
  endtask

  task automatic test_reset_mid;
    int dc = 0;
    logic [15:0] r; int lat, bc, dc2;
    @(negedge clk);
    a = 16'd1234; b = 16'd4321; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      if (done) dc++;
      if (cyc == 8) reset = 1'b1;
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid_busy: got %0b expected 0", busy); end
    tests++; if (result !== 16'd0) begin fails++; $display("FAIL reset_mid_result: got %0d expected 0", result); end
    tests++; if (dc != 0 || done !== 1'b0) begin fails++; $display("FAIL reset_mid_done: got %0d pulses expected 0", dc + int'(done)); end
    reset = 1'b0;
    run_op(16'd2, 16'd2, r, lat, bc, dc2);
    tests++; if (r !== 16'd4) begin fails++; $display("FAIL reset_mid_followup: got %0d expected 4", r); end
    $display("[TB] reset mid-op: busy=%0b followup 2*2=%0d", busy, r);
  endtask

  task automatic test_back_to_back;
    int d = 0;
    int c1 = 0, c2 = 0;
    logic [15:0] r1 = 16'd0, r2 = 16'd0;
    int e1, e2;
    @(negedge clk);
    a = 16'd3; b = 16'd5; start = 1'b1;
    @(posedge clk);
    #1 a = 16'd6; b = 16'd7;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        d++;
        if (d == 1) begin c1 = cyc; r1 = result; end
        if (d == 2) begin c2 = cyc; r2 = result; start = 1'b0; break; end
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    e1 = exp_lat(16'd5);
    e2 = e1 + 1 + exp_lat(16'd7);
    tests++; if (c1 != e1 || r1 !== 16'd15) begin fails++; $display("FAIL b2b_first: got cycle %0d result %0d expected cycle %0d result 15", c1, r1, e1); end
    tests++; if (c2 != e2 || r2 !== 16'd42) begin fails++; $display("FAIL b2b_second: got cycle %0d result %0d expected cycle %0d result 42", c2, r2, e2); end
    $display("[TB] back-to-back: done at %0d and %0d, results %0d %0d", c1, c2, r1, r2);
  endtask

  // Checks the ALU bus during each step against the partial product so far
  task automatic test_alu_bus;
    logic [15:0] oa, ob, ex_x, ex_y;
    logic [5:0]  ex_c;
    logic [31:0] low;
    int n, bad;
    oa = 16'($urandom); ob = 16'($urandom) | 16'h8001;
    n = exp_lat(ob) - 1;
    bad = 0;
    @(negedge clk);
    a = oa; b = ob; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      low  = (32'd1 << (k - 1)) - 32'd1;
      ex_x = ref_mul(oa, 16'(ob & low[15:0]));
      ex_y = 16'({16'd0, oa} << (k - 1));
      ex_c = ob[k-1] ? C_ADD : C_PASSX;
      tests++;
      if (alu_x !== ex_x || alu_y !== ex_y || alu_c !== ex_c) begin
        fails++; bad++;
        $display("FAIL alu_bus step %0d: got x=%0d y=%0d c=%b expected x=%0d y=%0d c=%b", k, alu_x, alu_y, alu_c, ex_x, ex_y, ex_c);
      end
    end
    @(negedge clk);
    tests++; if (done !== 1'b1 || alu_y !== 16'd0 || alu_c !== C_PASSX) begin fails++; $display("FAIL alu_bus_done: got done=%0b y=%0d c=%b expected done=1 y=0 c=%b", done, alu_y, alu_c, C_PASSX); end
    @(negedge clk);
    $display("[TB] alu bus %0d*%0d: %0d steps, %0d bad", oa, ob, n, bad);
  endtask

  task automatic test_random_sweep;
    logic [15:0] oa, ob, r; int lat, bc, dc;
    for (int i = 0; i < 50; i++) begin
      if (i < 25) begin
        oa = 16'(i * 100 + $urandom_range(0, 99));
        ob = 16'(i * 567);
      end else begin
        oa = 16'($urandom);
        ob = 16'($urandom);
      end
      run_op(oa, ob, r, lat, bc, dc);
      tests++;
      if (r !== ref_mul(oa, ob) || lat != exp_lat(ob) || dc != 1) begin
        fails++;
        $display("FAIL sweep %0d*%0d: got result %0d latency %0d pulses %0d expected result %0d latency %0d pulses 1", oa, ob, r, lat, dc, ref_mul(oa, ob), exp_lat(ob));
      end
      $display("[TB] sweep %0d*%0d = %0d latency %0d", oa, ob, r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_alu_bus();
    test_random_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
